// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Thirty-two registers, each tracked by a two-bit outstanding-producer counter.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer flop remembers which requester
// is favoured next and only advances when a grant is actually issued.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic ready0,
  output logic ready1,
  output logic grant0,
  output logic grant1
);
  // ptr_reg = 0: wb0 favoured, 1: wb1 favoured
  logic ptr_reg;
  logic ptr_next;

  // Each ready looks only at the other requester, never at its own valid.
  assign ready0 = !(req1 && ptr_reg);
  assign ready1 = !(req0 && !ptr_reg);
  assign grant0 = req0 && ready0;
  assign grant1 = req1 && ready1;

  always_comb begin
    ptr_next = ptr_reg;
    if (grant0) begin
      ptr_next = 1'b1;
    end else if (grant1) begin
      ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler and hazard scoreboard: arbitrates two writeback sources
// onto one register-file write port and tracks outstanding producers per register.
module regfile_write_sched
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_reg,
  output logic              iss_ready,
  input  logic              wb0_valid,
  input  logic [REG_W-1:0]  wb0_reg,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [REG_W-1:0]  wb1_reg,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic [REG_W-1:0]  rs_idx,
  input  logic [REG_W-1:0]  rt_idx,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              rf_regwrite,
  output logic [5:0]        rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              err_underflow
);
  logic grant0;
  logic grant1;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (wb0_valid),
    .req1   (wb1_valid),
    .ready0 (wb0_ready),
    .ready1 (wb1_ready),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  reg_idx_t          grant_reg;
  logic [DATA_W-1:0] grant_data;
  logic              regwrite_reg, regwrite_next;
  reg_idx_t          wreg_reg, wreg_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  cnt_reg [NUM_REGS];
  logic [NUM_REGS-1:0] uf_vec;
  logic              iss_fire;

  assign grant_reg  = grant0 ? wb0_reg  : wb1_reg;
  assign grant_data = grant0 ? wb0_data : wb1_data;

  // Writes to register 0 complete the handshake but never reach the file.
  always_comb begin
    regwrite_next = (grant0 || grant1) && (grant_reg != REG_ZERO);
    wreg_next     = wreg_reg;
    wdata_next    = wdata_reg;
    if (regwrite_next) begin
      wreg_next  = grant_reg;
      wdata_next = grant_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_reg <= 1'b0;
      wreg_reg     <= REG_ZERO;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      regwrite_reg <= regwrite_next;
      wreg_reg     <= wreg_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
    end
  end

  assign iss_ready = (cnt_reg[iss_reg] != CNT_MAX);
  assign iss_fire  = iss_valid && iss_ready && (iss_reg != REG_ZERO);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_reg[gi] = '0;
        assign uf_vec[gi]  = 1'b0;
      end else begin : g_live
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt_next;

        assign inc = iss_fire && (iss_reg == reg_idx_t'(gi));
        assign dec = regwrite_reg && (wreg_reg == reg_idx_t'(gi));
        assign uf_vec[gi] = dec && (cnt_reg[gi] == '0);

        // A commit against an empty counter saturates at zero instead of wrapping.
        always_comb begin
          cnt_next = cnt_reg[gi];
          if (inc && !dec) begin
            cnt_next = cnt_reg[gi] + 1'b1;
          end else if (dec && !inc && (cnt_reg[gi] != '0)) begin
            cnt_next = cnt_reg[gi] - 1'b1;
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt_reg[gi] <= '0;
          end else begin
            cnt_reg[gi] <= cnt_next;
          end
        end
      end
    end
  endgenerate

  assign err_next = err_reg || (|uf_vec);

  assign rs_busy       = (rs_idx != REG_ZERO) && (cnt_reg[rs_idx] != '0);
  assign rt_busy       = (rt_idx != REG_ZERO) && (cnt_reg[rt_idx] != '0);
  assign rf_regwrite   = regwrite_reg;
  assign rf_write_reg  = {1'b0, wreg_reg};
  assign rf_write_data = wdata_reg;
  assign err_underflow = err_reg;
endmodule
